// File: rtl/psram_ahbl_wbuf.sv
// AHB-Lite posted-write buffer for the PSRAM start/done core (data space only).
// Define PSRAM_WBUF_FWD_EN to forward word reads that hit the newest buffered word write.
module psram_ahbl_wbuf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 23
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic [23:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [2:0]  m_size,
    output logic        m_rd_wr,
    output logic        m_start,
    input  logic        m_done,
    input  logic [31:0] m_rdata,
    output logic        wbuf_empty
);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StWBusy, StRBusy} state_e;
    state_e state_q, state_d;

    logic          dp_valid_q, dp_write_q;
    logic [AW-1:0] dp_addr_q;
    logic [2:0]    dp_size_q;
    logic          rd_pend_q, rd_done_q;

    logic [AW-1:0] fifo_addr [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [2:0]    fifo_size [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   cnt_q;

    logic [23:0] m_addr_q;
    logic [31:0] m_wdata_q;
    logic [2:0]  m_size_q;
    logic        m_rd_wr_q;

    logic        addr_ph, wr_dp, rd_dp, fifo_empty, fifo_full, push, pop, go_w, go_r;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [2:0]  hsize_bytes;
    logic        unused;

    assign unused      = ^{HADDR[31:24], HTRANS[0]};
    assign addr_ph     = HSEL & HTRANS[1] & HREADY & ~HADDR[23];
    assign hsize_bytes = (HSIZE == 3'd0) ? 3'd1 : (HSIZE == 3'd1) ? 3'd2 : 3'd4;
    assign wr_dp       = dp_valid_q & dp_write_q;
    assign rd_dp       = dp_valid_q & ~dp_write_q;
    assign fifo_empty  = (cnt_q == '0);
    assign fifo_full   = (cnt_q == (PW+1)'(DEPTH));
    assign pop         = (state_q == StWBusy) & m_done;
    // A full FIFO still accepts when the head retires in the same cycle.
    assign push        = wr_dp & (~fifo_full | pop);
    assign go_w        = (state_q == StIdle) & ~fifo_empty;
    assign go_r        = (state_q == StIdle) & fifo_empty & rd_pend_q;
    assign HREADYOUT   = ~(wr_dp & ~push) & ~(rd_dp & ~rd_done_q);
    assign wbuf_empty  = fifo_empty & (state_q == StIdle) & ~m_start;

`ifdef PSRAM_WBUF_FWD_EN
    logic [PW-1:0] newest;
    assign newest   = wptr_q - PW'(1);
    assign fwd_hit  = rd_pend_q & ~fifo_empty & (dp_size_q == 3'd4) &
                      (fifo_size[newest] == 3'd4) &
                      (fifo_addr[newest][AW-1:2] == dp_addr_q[AW-1:2]);
    assign fwd_data = fifo_data[newest];
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= '0;
            dp_size_q  <= 3'd1;
        end else if (HREADY) begin
            dp_valid_q <= addr_ph;
            dp_write_q <= HWRITE;
            dp_addr_q  <= HADDR[AW-1:0];
            dp_size_q  <= hsize_bytes;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rd_pend_q <= 1'b0;
            rd_done_q <= 1'b0;
            HRDATA    <= '0;
        end else begin
            if (addr_ph && !HWRITE) begin
                rd_pend_q <= 1'b1;
            end else if ((state_q == StRBusy && m_done) || fwd_hit) begin
                rd_pend_q <= 1'b0;
            end
            if ((state_q == StRBusy && m_done) || fwd_hit) begin
                rd_done_q <= 1'b1;
            end else if (HREADY) begin
                rd_done_q <= 1'b0;
            end
            if (state_q == StRBusy && m_done) begin
                HRDATA <= m_rdata;
            end else if (fwd_hit) begin
                HRDATA <= fwd_data;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (push) begin
            fifo_addr[wptr_q] <= dp_addr_q;
            fifo_data[wptr_q] <= HWDATA;
            fifo_size[wptr_q] <= dp_size_q;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            if (push && !pop)      cnt_q <= cnt_q + (PW+1)'(1);
            else if (pop && !push) cnt_q <= cnt_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (go_w)      state_d = StWBusy;
                else if (go_r) state_d = StRBusy;
            end
            StWBusy, StRBusy: begin
                if (m_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Core command is presented live on the start cycle, then held from the capture registers.
    always_comb begin
        m_start = go_w | go_r;
        m_addr  = m_addr_q;
        m_wdata = m_wdata_q;
        m_size  = m_size_q;
        m_rd_wr = m_rd_wr_q;
        if (go_w) begin
            m_addr  = 24'(fifo_addr[rptr_q]);
            m_wdata = fifo_data[rptr_q];
            m_size  = fifo_size[rptr_q];
            m_rd_wr = 1'b0;
        end else if (go_r) begin
            m_addr  = 24'(dp_addr_q);
            m_size  = dp_size_q;
            m_rd_wr = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_size_q  <= 3'd1;
            m_rd_wr_q <= 1'b0;
        end else if (m_start) begin
            m_addr_q  <= m_addr;
            m_wdata_q <= m_wdata;
            m_size_q  <= m_size;
            m_rd_wr_q <= m_rd_wr;
        end
    end

endmodule

// File: tb/tb_psram_ahbl_wbuf.sv
// Self-checking bench for psram_ahbl_wbuf: vector table, core model and start scoreboard.
module tb_psram_ahbl_wbuf;
    localparam int CORE_LAT = 1;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic [23:0] m_addr;
    logic [31:0] m_wdata;
    logic [2:0]  m_size;
    logic        m_rd_wr;
    logic        m_start;
    logic        m_done;
    logic [31:0] m_rdata;
    logic        wbuf_empty;

    assign HREADY = HREADYOUT;

    psram_ahbl_wbuf #(.DEPTH(4), .AW(23)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_size(m_size), .m_rd_wr(m_rd_wr), .m_start(m_start), .m_done(m_done),
        .m_rdata(m_rdata), .wbuf_empty(wbuf_empty)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        wr;
        logic        ign;
        logic [31:0] addr;
        logic [31:0] data;      // write data, or expected read data
        logic [2:0]  hsize;
        logic [2:0]  msize;
        int          wait_exp;  // -1 unchecked, -2 must stall, else exact stall cycles
    } vec_t;

    typedef struct {
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic        rd;
    } exp_t;

    vec_t vt[20];
    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   done_total = 0;
    int   start_total = 0;
    int   acc_done[20];

    // Core model: fixed latency, stall while core_hold, word-indexed backing store.
    logic        core_busy, core_hold, core_rd;
    logic [1:0]  core_cnt;
    logic [7:0]  core_idx;
    logic [31:0] cmem [256];

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            core_busy <= 1'b0;
            core_rd   <= 1'b0;
            core_cnt  <= '0;
            core_idx  <= '0;
            m_done    <= 1'b0;
            m_rdata   <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_start) begin
                core_busy <= 1'b1;
                core_cnt  <= 2'(CORE_LAT);
                core_rd   <= m_rd_wr;
                core_idx  <= m_addr[9:2];
                if (!m_rd_wr) cmem[m_addr[9:2]] <= m_wdata;
            end else if (core_busy && !core_hold) begin
                if (core_cnt == 2'd0) begin
                    m_done     <= 1'b1;
                    core_busy  <= 1'b0;
                    done_total <= done_total + 1;
                    if (core_rd) m_rdata <= cmem[core_idx];
                end else begin
                    core_cnt <= core_cnt - 2'd1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Start monitor: every m_start is popped against the scoreboard; command held while busy.
    logic [23:0] cap_addr;
    logic        cap_rd;
    initial begin
        exp_t e;
        cap_addr = '0;
        cap_rd   = 1'b0;
        forever begin
            @(negedge HCLK);
            if (HRESETn && m_start) begin
                start_total++;
                check("start_core_idle", 32'(core_busy), 32'd0);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_start: addr 0x%06h rd %0b, none expected",
                             m_addr, m_rd_wr);
                end else begin
                    e = exp_q.pop_front();
                    check("start_addr", 32'(m_addr), 32'(e.addr));
                    check("start_rd_wr", 32'(m_rd_wr), 32'(e.rd));
                    check("start_size", 32'(m_size), 32'(e.size));
                    if (!e.rd) check("start_wdata", m_wdata, e.wdata);
                end
                cap_addr = m_addr;
                cap_rd   = m_rd_wr;
            end else if (HRESETn && core_busy) begin
                check("cmd_held", {7'd0, m_rd_wr, m_addr}, {7'd0, cap_rd, cap_addr});
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_hreadyout"}, 32'(HREADYOUT), 32'd1);
        check({tag, "_hrdata"}, HRDATA, 32'd0);
        check({tag, "_m_start"}, 32'(m_start), 32'd0);
        check({tag, "_m_addr"}, 32'(m_addr), 32'd0);
        check({tag, "_m_wdata"}, m_wdata, 32'd0);
        check({tag, "_m_size"}, 32'(m_size), 32'd1);
        check({tag, "_m_rd_wr"}, 32'(m_rd_wr), 32'd0);
        check({tag, "_wbuf_empty"}, 32'(wbuf_empty), 32'd1);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || core_busy || !wbuf_empty) && n < 500) begin
            @(negedge HCLK);
            n++;
        end
        check({tag, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_wbuf_empty"}, 32'(wbuf_empty), 32'd1);
    endtask

    // Pipelined AHB burst over vt[first +: n]; expectations queued as each data phase opens.
    task automatic run_burst(input int first, input int n);
        int   st;
        int   idx;
        vec_t v;
        exp_t e;
        @(posedge HCLK);
        #1;
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                v      = vt[first + i];
                HSEL   = 1'b1;
                HTRANS = 2'b10;
                HADDR  = v.addr;
                HWRITE = v.wr;
                HSIZE  = v.hsize;
            end else begin
                HSEL   = 1'b0;
                HTRANS = 2'b00;
                HWRITE = 1'b0;
            end
            if (i > 0) begin
                v      = vt[first + i - 1];
                HWDATA = v.wr ? v.data : 32'h0;
                if (!v.ign) begin
                    e.addr  = 24'(v.addr[22:0]);
                    e.wdata = v.data;
                    e.size  = v.msize;
                    e.rd    = !v.wr;
                    exp_q.push_back(e);
                end
            end
            st = 0;
            @(negedge HCLK);
            while (!HREADYOUT && st < 300) begin
                st++;
                @(negedge HCLK);
            end
            if (st >= 300) begin
                n_vec++;
                n_err++;
                $display("FAIL ready_timeout: vector %0d still stalled after %0d cycles",
                         first + i - 1, st);
            end
            if (i > 0) begin
                idx = first + i - 1;
                v   = vt[idx];
                acc_done[idx] = done_total;
                if (v.wait_exp == -2)
                    check($sformatf("v%0d_stalled", idx), 32'(st > 0), 32'd1);
                else if (v.wait_exp >= 0)
                    check($sformatf("v%0d_wait", idx), 32'(st), 32'(v.wait_exp));
                if (!v.wr) check($sformatf("v%0d_hrdata", idx), HRDATA, v.data);
            end
            @(posedge HCLK);
            #1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int dt0;
        int s0;
        //          wr    ign   addr           data          hsz   msz   wait
        vt[0]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_00A0, 3'd2, 3'd4, 0};
        vt[1]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_00A1, 3'd2, 3'd4, 0};
        vt[2]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0000_00A2, 3'd2, 3'd4, 0};
        vt[3]  = '{1'b1, 1'b0, 32'h0000_000C, 32'h0000_00A3, 3'd2, 3'd4, 0};
        vt[4]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h1234_5678, 3'd2, 3'd4, 0};
        vt[5]  = '{1'b0, 1'b0, 32'h0000_0040, 32'h1234_5678, 3'd2, 3'd4, -1};
        vt[6]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_00A0, 3'd2, 3'd4, CORE_LAT + 3};
        vt[7]  = '{1'b1, 1'b0, 32'h0000_0003, 32'h0000_005A, 3'd0, 3'd1, 0};
        vt[8]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_BEEF, 3'd1, 3'd2, 0};
        vt[9]  = '{1'b1, 1'b1, 32'h0080_0004, 32'hDEAD_0000, 3'd2, 3'd4, 0};
        vt[10] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0000_00A1, 3'd2, 3'd4, -1};
        for (int i = 0; i < 5; i++)
            vt[11 + i] = '{1'b1, 1'b0, 32'h80 + 32'(4 * i), 32'hB0 + 32'(i), 3'd2, 3'd4,
                           (i == 4) ? -2 : 0};
        for (int i = 0; i < 4; i++)
            vt[16 + i] = '{1'b1, 1'b0, 32'hC0 + 32'(4 * i), 32'hC0 + 32'(i), 3'd2, 3'd4, 0};

        HRESETn   = 1'b0;
        HSEL      = 1'b0;
        HADDR     = '0;
        HWDATA    = '0;
        HTRANS    = 2'b00;
        HSIZE     = 3'd2;
        HWRITE    = 1'b0;
        core_hold = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        check_reset("reset");
        HRESETn = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
        check_reset("idle");

        run_burst(0, 4);
        wait_drain("word_writes");
        run_burst(4, 2);
        wait_drain("raw_read");
        run_burst(6, 5);
        wait_drain("mixed");

        // Full FIFO with the core stalled: fifth write must wait for the first completion.
        core_hold = 1'b1;
        dt0 = done_total;
        fork
            run_burst(11, 5);
            begin
                repeat (8) @(posedge HCLK);
                @(negedge HCLK);
                core_hold = 1'b0;
            end
        join
        check("fourth_accept_before_done", 32'(acc_done[14]), 32'(dt0));
        check("fifth_accept_after_done", 32'(acc_done[15] > dt0), 32'd1);
        wait_drain("stall");

        // Reset while the core is busy with three more writes queued.
        core_hold = 1'b1;
        run_burst(16, 4);
        repeat (2) @(negedge HCLK);
        check("pre_reset_wbuf_busy", 32'(wbuf_empty), 32'd0);
        HRESETn = 1'b0;
        #2;
        check_reset("mid_reset");
        exp_q.delete();
        core_hold = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        s0 = start_total;
        repeat (20) @(negedge HCLK);
        check("no_start_after_reset", 32'(start_total), 32'(s0));
        check("post_reset_wbuf_empty", 32'(wbuf_empty), 32'd1);
        check("post_reset_hreadyout", 32'(HREADYOUT), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
